instr_prefetch: RTL
===================

# instr_prefetch

Word-aligned instruction prefetch buffer sitting between the instruction memory bus and the fetch/realign stage. It issues sequential 32-bit fetch requests, queues returned words in a small FIFO, and presents the head word with a ready flag to the fetch stage. It restarts on a jump and discards stale responses. The fetch stage consumes the word it splits into compressed/uncompressed instructions with a pop pulse.

## Interface
Parameters:
- Depth, 2: FIFO entries; also the maximum number of words in flight plus buffered (≥2).
- ResetAddr, 32'h0: first fetch address after reset; must be word-aligned.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- jump_flag_i  in  1  flush and restart.
- jump_addr_i  in  InstAddrBus  restart target; bits [1:0] ignored.
- fetch_pop_i  in  1  fetch stage consumed head word.
- instr_o  out  InstBus  head word.
- instr_ready_o  out  1  instr_o valid.
- instr_addr_word_o  out  InstAddrBus  word address of head word.
- mem_req_o  out  1  bus request.
- mem_addr_o  out  InstAddrBus  bus address, bits [1:0] always 0.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  response data valid.
- mem_rdata_i  in  InstBus  response data.

## Operation
- Bus protocol: request accepted when mem_req_o && mem_gnt_i. Responses return in order, at least 1 cycle after grant. Once mem_req_o is raised, it and mem_addr_o stay stable until granted.
- Credit rule: a new request is raised only if fifo_count + outstanding < Depth, so a response always has a free slot.
- FSM states:
  - IDLE: mem_req_o = 0. Moves to REQ when credit is available and the block is not in reset.
  - REQ: mem_req_o = 1. On grant: fetch_addr += 4, outstanding++, and the state stays REQ if credit remains, else goes to IDLE.
- Jump:
  - fetch_addr ← {jump_addr_i[31:2],2'b00} and the FIFO is cleared.
  - discard_cnt ← outstanding; it also includes a request granted in the jump cycle.
  - If REQ is ungranted at the jump, the old address stays on the bus until granted, that response is discarded, and the new address follows.
- Response: if discard_cnt > 0, the response is dropped and discard_cnt decremented. Otherwise it is pushed with its word address. outstanding is decremented either way.
- Pop: removes the head entry. A pop while instr_ready_o = 0 is ignored. A pop in the jump cycle is overridden by the flush.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Counters: fifo_count is $clog2(Depth+1) bits; outstanding and discard_cnt are the same width.

## Timing
- Reset values: mem_req_o = 0, mem_addr_o = ResetAddr, instr_ready_o = 0, instr_o = 0, instr_addr_word_o = 0. FIFO is empty and all counters are 0.
- First request: mem_req_o rises in the first clk_i edge-cycle after rst_ni deasserts.
- Latency without bypass: rvalid in cycle N gives instr_ready_o in cycle N+1.
- Push and pop in the same cycle are legal at any fill level, including full.
- Jump in cycle N:
  - instr_ready_o = 0 from cycle N+1.
  - The new-address request appears no earlier than N+1.
- Reset mid-operation: all state returns to reset values immediately. In-flight responses are not tracked; the bus is reset together with this block.

## Configuration
- Macro: INSTR_PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard_cnt = 0 and mem_rvalid_i = 1:
  - instr_o = mem_rdata_i and instr_ready_o = 1 combinationally in that same cycle.
  - If fetch_pop_i is also 1, the word is not written to the FIFO.
- Undefined: all output data is taken from FIFO registers and the latency is 1 cycle, as described under Timing.

## Structure
- tinyriscv_pkg:
  - Existing InstAddrBus and InstBus.
  - New typedef prefetch_state_e {PF_IDLE, PF_REQ}.
  - New typedef prefetch_entry_t {addr, data}.
- Sub-module prefetch_fifo: generic Depth-entry synchronous FIFO of prefetch_entry_t with flush_i, push_i, pop_i, full_o, empty_o, count_o and async active-low reset.

## Test plan
- Reset, gnt = 1, rvalid 1 cycle later, rdata = 32'h0000_0013 and incrementing:
  - mem_addr_o sequence 0x0, 0x4, 0x8.
  - Heads 0x13, … with instr_addr_word_o matching.
- No pops, Depth = 2, continuous gnt: exactly 2 grants, then mem_req_o = 0. After one pop, exactly one more request.
- Jump to 0x0000_0106 with 2 outstanding:
  - Both old responses are dropped.
  - Next mem_addr_o = 0x104.
  - First head is the 0x104 word.
- Jump while REQ is ungranted (gnt held 0 for 3 cycles at addr 0x8): 0x8 is held until granted, its data is discarded, then the request goes to the jump target.
- fetch_addr = 0xFFFF_FFF8, continuous flow: requests are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With INSTR_PREFETCH_BYPASS_EN, FIFO empty, rvalid = 1 and pop = 1 in the same cycle:
  - instr_ready_o = 1 in that cycle.
  - FIFO count stays 0.
- Without the macro, instr_ready_o = 1 one cycle later.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared bus types and prefetch-buffer types for the instruction fetch path.
package tinyriscv_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  typedef enum logic [0:0] {
    PF_IDLE = 1'b0,
    PF_REQ  = 1'b1
  } prefetch_state_e;

  typedef struct packed {
    InstAddrBus addr;
    InstBus     data;
  } prefetch_entry_t;

  // Fetches are always whole 32-bit words.
  function automatic InstAddrBus word_align(input InstAddrBus a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Depth-entry synchronous FIFO of prefetch entries with flush; push and pop may
// coincide at any fill level, including full.
module prefetch_fifo
  import tinyriscv_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  prefetch_entry_t push_data_i,
  input  logic            pop_i,
  output prefetch_entry_t head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  prefetch_entry_t mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Sequential word prefetcher with jump restart and stale-response discard.
// Optional INSTR_PREFETCH_BYPASS_EN forwards a response straight to the fetch stage when the FIFO is empty.
module instr_prefetch
  import tinyriscv_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter InstAddrBus  ResetAddr = 32'h0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       jump_flag_i,
  input  InstAddrBus jump_addr_i,
  input  logic       fetch_pop_i,
  output InstBus     instr_o,
  output logic       instr_ready_o,
  output InstAddrBus instr_addr_word_o,
  output logic       mem_req_o,
  output InstAddrBus mem_addr_o,
  input  logic       mem_gnt_i,
  input  logic       mem_rvalid_i,
  input  InstBus     mem_rdata_i
);

  localparam int unsigned CntW      = $clog2(Depth + 1);
  localparam InstAddrBus  ResetWord = ResetAddr & ~32'h3;

  // state_q is the FSM state; probe it hierarchically when debugging.
  prefetch_state_e state_q, state_d;
  InstAddrBus      fetch_addr_q, fetch_addr_d;
  InstAddrBus      rsp_addr_q, rsp_addr_d;
  InstAddrBus      redir_addr_q, redir_addr_d;
  logic            redir_pend_q, redir_pend_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  prefetch_entry_t fifo_head, push_entry;
  logic            grant, rsp_keep, rsp_drop, credit, credit_after_grant;
  logic [31:0]     inflight;
  InstAddrBus      jump_word;

  assign grant              = (state_q == PF_REQ) && mem_gnt_i;
  assign rsp_drop           = mem_rvalid_i && (discard_q != '0);
  assign rsp_keep           = mem_rvalid_i && (discard_q == '0);
  assign inflight           = 32'(fifo_count) + 32'(outstanding_q);
  assign credit             = !fifo_full && (inflight < Depth);
  assign credit_after_grant = (inflight + 32'd1) < Depth;
  assign fifo_pop           = fetch_pop_i && !fifo_empty;
  assign push_entry         = '{addr: rsp_addr_q, data: mem_rdata_i};
  assign jump_word          = word_align(jump_addr_i);

  assign mem_req_o  = (state_q == PF_REQ);
  assign mem_addr_o = fetch_addr_q;

`ifdef INSTR_PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit        = fifo_empty && rsp_keep;
  assign instr_ready_o     = !fifo_empty || bypass_hit;
  assign instr_o           = !fifo_empty ? fifo_head.data :
                             (bypass_hit ? mem_rdata_i : '0);
  assign instr_addr_word_o = !fifo_empty ? fifo_head.addr :
                             (bypass_hit ? rsp_addr_q : '0);
  assign fifo_push         = rsp_keep && !(bypass_hit && fetch_pop_i);
`else
  assign instr_ready_o     = !fifo_empty;
  assign instr_o           = !fifo_empty ? fifo_head.data : '0;
  assign instr_addr_word_o = !fifo_empty ? fifo_head.addr : '0;
  assign fifo_push         = rsp_keep;
`endif

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q + CntW'(grant) - CntW'(mem_rvalid_i);
    discard_d     = rsp_drop ? discard_q - CntW'(1) : discard_q;
    rsp_addr_d    = rsp_keep ? rsp_addr_q + 32'd4 : rsp_addr_q;
    fetch_addr_d  = grant ? fetch_addr_q + 32'd4 : fetch_addr_q;
    redir_addr_d  = redir_addr_q;
    redir_pend_d  = redir_pend_q;

    // Everything still in flight after this edge is stale once we jump.
    if (jump_flag_i) begin
      discard_d  = outstanding_d;
      rsp_addr_d = jump_word;
      if ((state_q == PF_REQ) && !mem_gnt_i) begin
        fetch_addr_d = fetch_addr_q;
        redir_addr_d = jump_word;
        redir_pend_d = 1'b1;
      end else begin
        fetch_addr_d = jump_word;
        redir_pend_d = 1'b0;
      end
    end else if (grant && redir_pend_q) begin
      fetch_addr_d = redir_addr_q;
      redir_pend_d = 1'b0;
      discard_d    = discard_d + CntW'(1);
    end

    case (state_q)
      PF_IDLE: if (credit) state_d = PF_REQ;
      PF_REQ:  if (grant && !credit_after_grant) state_d = PF_IDLE;
      default: state_d = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= PF_IDLE;
      fetch_addr_q  <= ResetWord;
      rsp_addr_q    <= ResetWord;
      redir_addr_q  <= '0;
      redir_pend_q  <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      rsp_addr_q    <= rsp_addr_d;
      redir_addr_q  <= redir_addr_d;
      redir_pend_q  <= redir_pend_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  prefetch_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (jump_flag_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
